vreg_xfer_seq: RTL

VREG_XFER_SEQ -- requirements
Module: vreg_xfer_seq

---
 rtl/vreg_xfer_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vreg_xfer_seq.sv
// vreg_xfer_seq: moves one vector register to or from LANES consecutive GPRs.
//   Load  (dir=0): read GPR base..base+LANES-1 one per cycle, then write the
//                  assembled vector into vreg_idx in a single cycle.
//   Store (dir=1): read vreg_idx in one cycle, then write its lanes to
//                  GPR base..base+LANES-1 one per cycle (GPR0 writes suppressed).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, dir                 transfer request and direction
//   gpr_base, vreg_idx         first GPR index, vector register index
//   busy, done, err            status: active, completion pulse, rejected start
//   gpr_addr/we/wdata/rdata    GPR file port (rdata combinational from addr)
//   vreg_addr/we/wdata/rdata   vector register file port (rdata combinational)
// Handshake: start is a single-cycle request with no ready. It is taken when
// the block is IDLE or in the final beat of a transfer (the done cycle), so
// transfers can chain back-to-back; at any other time start is dropped.
module vreg_xfer_seq #(
    parameter int LANES = 4,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dir,
    input  logic [4:0]         gpr_base,
    input  logic [4:0]         vreg_idx,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [4:0]         gpr_addr,
    output logic               gpr_we,
    output logic [W-1:0]       gpr_wdata,
    input  logic [W-1:0]       gpr_rdata,
    output logic [4:0]         vreg_addr,
    output logic               vreg_we,
    output logic [LANES*W-1:0] vreg_wdata,
    input  logic [LANES*W-1:0] vreg_rdata
);

    localparam int VW = LANES * W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(LANES - 1);
    localparam logic [5:0]    MAX_BASE  = 6'(32 - LANES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LRD  = 3'd1,
        LWR  = 3'd2,
        SRD  = 3'd3,
        SWR  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic [4:0]      base_q, base_d;
    logic [4:0]      vidx_q, vidx_d;
    logic [VW-1:0]   buf_q, buf_d;
    logic            err_q, err_d;

    logic [4:0]      beat_addr;
    logic            base_ok;

    assign beat_addr = base_q + 5'(cnt_q);
    assign base_ok   = ({1'b0, gpr_base} <= MAX_BASE);
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            base_q  <= '0;
            vidx_q  <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            base_q  <= base_d;
            vidx_q  <= vidx_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        base_d     = base_q;
        vidx_d     = vidx_q;
        buf_d      = buf_q;
        err_d      = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        gpr_addr   = '0;
        gpr_we     = 1'b0;
        gpr_wdata  = '0;
        vreg_addr  = '0;
        vreg_we    = 1'b0;
        vreg_wdata = '0;

        case (state_q)
            LRD: begin
                gpr_addr = beat_addr;
                buf_d[cnt_q*W +: W] = gpr_rdata;
                if (cnt_q == LAST_BEAT) begin
                    state_d = LWR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LWR: begin
                vreg_addr  = vidx_q;
                vreg_we    = 1'b1;
                vreg_wdata = buf_q;
                done       = 1'b1;
                state_d    = IDLE;
            end
            SRD: begin
                vreg_addr = vidx_q;
                buf_d     = vreg_rdata;
                state_d   = SWR;
                cnt_d     = '0;
            end
            SWR: begin
                gpr_addr  = beat_addr;
                gpr_wdata = buf_q[cnt_q*W +: W];
                // GPR0 is hardwired zero: the beat runs but never writes.
                gpr_we    = (beat_addr != 5'd0);
                if (cnt_q == LAST_BEAT) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start is honoured in IDLE and in the done cycle (which returns to
        // IDLE anyway), so a chained transfer begins with no dead cycle.
        if (start && (state_q == IDLE || done)) begin
            if (base_ok) begin
                dir_d   = dir;
                base_d  = gpr_base;
                vidx_d  = vreg_idx;
                cnt_d   = '0;
                state_d = dir ? SRD : LRD;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

endmodule
